kulisch_acc_ctrl: RTL and testbench

Sequencing controller for the Kulisch dot-product accumulator datapath. It accepts a stream of product beats under a valid/ready handshake and holds the 92-bit carry-save accumulator pair in registers. Each accepted beat closes the loop through the combinational accumulator tree. On the last beat it resolves sum+carry into a single two's-complement fixed-point result with a multi-cycle chunked carry-propagate adder. The result is presented under a valid/ready handshake to the downstream normaliser.

---
 rtl/kulisch_acc_ctrl.sv | 122 ++++++++++++
 tb/tb_kulisch_acc_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/kulisch_acc_ctrl.sv
// Sequencer for the Kulisch carry-save accumulator: holds the sum/carry pair,
// resolves it with a chunked carry-propagate adder, and hands the result downstream.
module kulisch_acc_ctrl #(
  parameter int AWIDTH = 92,
  parameter int CHUNK  = 23,
  parameter int CWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic              i_last,
  output logic              o_ready,
  input  logic              i_flush,
  output logic [AWIDTH-1:0] o_dp_sum_acc,
  output logic [AWIDTH-1:0] o_dp_carry_acc,
  input  logic [AWIDTH-1:0] i_dp_sum_acc,
  input  logic [AWIDTH-1:0] i_dp_carry_acc,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [AWIDTH-1:0] o_res,
  output logic [CWIDTH-1:0] o_beat_cnt,
  output logic              o_busy
);
  localparam int NCHUNK = AWIDTH / CHUNK;
  localparam int JW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [JW-1:0] JLAST = JW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, OUTPUT} state_t;

  state_t              state_q, state_d;
  logic [AWIDTH-1:0]   sum_q, sum_d, carry_q, carry_d, res_q, res_d;
  logic [CWIDTH-1:0]   cnt_q, cnt_d;
  logic [JW-1:0]       j_q, j_d;
  logic                c_q, c_d;
  logic [CHUNK:0]      add;
  logic                accept;

  assign o_ready = ((state_q == IDLE) || (state_q == ACCUM)) && !i_flush;
  assign accept  = i_valid && o_ready;

  // One chunk of the carry-propagate adder, selected by the resolve index.
  assign add = {1'b0, sum_q[j_q*CHUNK +: CHUNK]} + {1'b0, carry_q[j_q*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, c_q};

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    j_d     = j_q;
    c_d     = c_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (i_flush) begin
          sum_d   = '0;
          carry_d = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (accept) begin
          sum_d   = i_dp_sum_acc;
          carry_d = i_dp_carry_acc;
          if (state_q == IDLE)  cnt_d = CWIDTH'(1);
          else if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (i_last) begin
            state_d = RESOLVE;
            j_d     = '0;
            c_d     = 1'b0;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      RESOLVE: begin
        res_d[j_q*CHUNK +: CHUNK] = add[CHUNK-1:0];
        c_d = add[CHUNK];
        j_d = j_q + 1'b1;
        if (j_q == JLAST) begin
          state_d = OUTPUT;
          j_d     = '0;
        end
      end
      OUTPUT: begin
        if (i_res_ready) begin
          sum_d   = '0;
          carry_d = '0;
          cnt_d   = '0;
          c_d     = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sum_q   <= '0;
      carry_q <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      j_q     <= '0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      c_q     <= c_d;
    end
  end

  assign o_dp_sum_acc   = sum_q;
  assign o_dp_carry_acc = carry_q;
  assign o_res          = res_q;
  assign o_res_valid    = (state_q == OUTPUT);
  assign o_beat_cnt     = cnt_q;
  assign o_busy         = (state_q != IDLE);
endmodule

// File: tb/tb_kulisch_acc_ctrl.sv
// Bench for kulisch_acc_ctrl: stub datapath adds each beat onto the accumulator pair;
// expected results come from a plain modulo-2^92 running total.
module tb_kulisch_acc_ctrl;
  localparam int AW = 92;
  localparam int NCH = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          i_valid = 0, i_last = 0, i_flush = 0, i_res_ready = 0;
  logic          o_ready, o_res_valid, o_busy;
  logic [AW-1:0] o_dp_sum_acc, o_dp_carry_acc, i_dp_sum_acc, i_dp_carry_acc, o_res;
  logic [15:0]   o_beat_cnt;
  logic [AW-1:0] bs = '0, bc = '0;

  int n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  assign i_dp_sum_acc   = o_dp_sum_acc + bs;
  assign i_dp_carry_acc = o_dp_carry_acc + bc;

  kulisch_acc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_last(i_last), .o_ready(o_ready),
    .i_flush(i_flush), .o_dp_sum_acc(o_dp_sum_acc), .o_dp_carry_acc(o_dp_carry_acc),
    .i_dp_sum_acc(i_dp_sum_acc), .i_dp_carry_acc(i_dp_carry_acc),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res(o_res),
    .o_beat_cnt(o_beat_cnt), .o_busy(o_busy));

  typedef struct { logic [AW-1:0] s, c, exp; } vec_t;
  vec_t tbl[5];

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic beat(input logic [AW-1:0] s, input logic [AW-1:0] c, input bit last);
    int n = 0;
    i_valid = 1'b1; i_last = last; bs = s; bc = c;
    @(negedge clk);
    while (!o_ready && n < 50) begin @(negedge clk); n++; end
    if (!o_ready) chk("beat_accept_timeout", 96'(o_ready), 96'd1);
    @(posedge clk); #1;
    i_valid = 1'b0; i_last = 1'b0; bs = '0; bc = '0;
  endtask

  // Called just after the last-beat edge; returns edges until o_res_valid is seen.
  task automatic wait_res(output int n);
    n = 1;
    @(negedge clk);
    while (!o_res_valid && n < 100) begin @(negedge clk); n++; end
    if (!o_res_valid) chk("res_valid_timeout", 96'(o_res_valid), 96'd1);
    n = n - 1;
  endtask

  task automatic take_res(input string nm, input logic [AW-1:0] exp, input int hold,
                          input logic [15:0] cnt);
    logic [AW-1:0] r0;
    r0 = o_res;
    chk({nm, "_res"}, 96'(o_res), 96'(exp));
    chk({nm, "_cnt"}, 96'(o_beat_cnt), 96'(cnt));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({nm, "_hold"}, {o_res_valid, o_ready, o_res}, {1'b1, 1'b0, r0});
    end
    i_res_ready = 1'b1;
    @(posedge clk); #1;
    i_res_ready = 1'b0;
    chk({nm, "_after"}, {o_ready, o_busy, o_res_valid, 16'(o_beat_cnt)}, 96'h4_0000);
  endtask

  initial begin
    logic [95:0]   r;
    logic [AW-1:0] s, c, model;
    int lat, nb;

    tbl[0] = '{92'd5, 92'd3, 92'd8};
    tbl[1] = '{(92'd1 << 23) - 92'd1, 92'd1, 92'd1 << 23};
    tbl[2] = '{(92'd1 << 69) - 92'd1, 92'd1, 92'd1 << 69};
    tbl[3] = '{'1, 92'd1, 92'd0};
    tbl[4] = '{'1, '1, '1 - 92'd1};

    #12;
    chk("reset_outputs", {o_ready, o_res_valid, o_busy, o_beat_cnt, o_res},
        {1'b1, 1'b0, 1'b0, 16'd0, 92'd0});
    chk("reset_dp", {4'd0, o_dp_sum_acc | o_dp_carry_acc}, 96'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-beat table
    for (int i = 0; i < 5; i++) begin
      beat(tbl[i].s, tbl[i].c, 1'b1);
      chk("resolve_busy", {o_busy, o_ready}, 96'b10);
      wait_res(lat);
      chk("latency", 96'(lat), 96'(NCH));
      take_res($sformatf("vec%0d", i), tbl[i].exp, 0, 16'd1);
    end

    // Stream of 10 beats with gaps, then result backpressure
    for (int b = 0; b < 10; b++) begin
      if (b % 2 == 0 && b != 0) begin @(posedge clk); #1; end
      beat(92'd7, 92'd0, b == 9);
    end
    wait_res(lat);
    take_res("stream", 92'd70, 5, 16'd10);

    // Flush in ACCUM with a simultaneous beat
    for (int b = 0; b < 3; b++) beat(92'd3, 92'd2, 1'b0);
    chk("pre_flush_cnt", 96'(o_beat_cnt), 96'd3);
    i_valid = 1'b1; bs = 92'd100; i_flush = 1'b1;
    @(negedge clk);
    chk("flush_ready", 96'(o_ready), 96'd0);
    @(posedge clk); #1;
    i_valid = 1'b0; i_flush = 1'b0; bs = '0;
    chk("flush_clear", {o_busy, o_beat_cnt, o_dp_sum_acc | o_dp_carry_acc}, 96'd0);
    beat(92'd4, 92'd0, 1'b0);
    beat(92'd4, 92'd0, 1'b1);
    wait_res(lat);
    take_res("post_flush", 92'd8, 0, 16'd2);

    // Reset in the second resolve cycle
    beat(92'd9, 92'd0, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {o_ready, o_res_valid, o_busy, o_beat_cnt, o_res},
        {1'b1, 1'b0, 1'b0, 16'd0, 92'd0});
    @(negedge clk); rst_n = 1'b1;
    lat = 0;
    for (int k = 0; k < 10; k++) begin @(negedge clk); lat += int'(o_res_valid); end
    chk("no_res_after_reset", 96'(lat), 96'd0);
    @(posedge clk); #1;
    beat(92'd1, 92'd1, 1'b1);
    wait_res(lat);
    take_res("post_reset", 92'd2, 0, 16'd1);

    // Random dot products against a running modulo-2^92 total
    for (int t = 0; t < 20; t++) begin
      model = '0;
      nb = $urandom_range(1, 8);
      for (int b = 0; b < nb; b++) begin
        r = {$urandom, $urandom, $urandom}; s = r[AW-1:0];
        r = {$urandom, $urandom, $urandom}; c = r[AW-1:0];
        model = model + s + c;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        beat(s, c, b == nb - 1);
      end
      wait_res(lat);
      chk("rand_latency", 96'(lat), 96'(NCH));
      take_res($sformatf("rand%0d", t), model, $urandom_range(0, 3), 16'(nb));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
